// File: rtl/apb3_eg_master_pkg.sv
// Shared types and constants for the APB3 example master: FSM encoding,
// response-register layout and wait-counter width.
package apb3_eg_master_pkg;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  localparam rsp_t RSP_RESET = '0;

  function automatic rsp_t rsp_pack(input logic [31:0] rdata, input logic err,
                                    input logic timeout);
    rsp_t r;
    r.rdata   = rdata;
    r.err     = err;
    r.timeout = timeout;
    return r;
  endfunction

endpackage

// File: rtl/apb3_eg_master_if.sv
// Command, response and APB3 bus signals of the example master, with the
// master (DUT) view and the slave (environment) view.
interface apb3_eg_master_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [31:0]          cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [31:0]          pwdata;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb3_eg_master_timer.sv
// Wait-state counter for the ACCESS phase: cleared by start, advanced by inc,
// flags expiry on the last permitted wait cycle. TIMEOUT=0 never expires.
module apb3_eg_master_timer
  import apb3_eg_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_inc,
  output logic o_expired
);
  localparam bit                   LP_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] LP_STOP = LP_EN ? TIMEOUT_W'(TIMEOUT) : '1;

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LP_STOP)) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign o_expired = LP_EN && (r_count == LP_LAST);

endmodule

// File: rtl/apb3_eg_master.sv
// Single-outstanding APB3 initiator: valid/ready command in, one-entry
// response register out, with optional PREADY timeout abort.
module apb3_eg_master
  import apb3_eg_master_pkg::*;
#(
  parameter int ADDRWIDTH = 12,
  parameter int TIMEOUT   = 16
) (
  input logic              pclk,
  input logic              preset,
  apb3_eg_master_if.master bus
);
  state_t               r_state;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDRWIDTH-1:0] r_paddr;
  logic [31:0]          r_pwdata;
  logic                 r_rsp_valid;
  rsp_t                 r_rsp;

  logic w_cmd_ready;
  logic w_accept;
  logic w_done;
  logic w_abort;
  logic w_expired;

  assign w_cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_done      = (r_state == ST_ACCESS) && r_psel && r_penable && bus.pready;
  // Completion is checked first, so pready on the final permitted cycle wins.
  assign w_abort     = (r_state == ST_ACCESS) && !bus.pready && w_expired;

  apb3_eg_master_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (pclk),
    .rst       (preset),
    .i_start   (r_state == ST_SETUP),
    .i_inc     ((r_state == ST_ACCESS) && !bus.pready),
    .o_expired (w_expired)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr & ~ADDRWIDTH'(3);
            r_pwdata <= bus.cmd_wdata;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done || w_abort) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= RSP_RESET;
    end else if (w_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp       <= rsp_pack(r_pwrite ? 32'h0 : bus.prdata, bus.pslverr, 1'b0);
    end else if (w_abort) begin
      r_rsp_valid <= 1'b1;
      r_rsp       <= rsp_pack(32'h0, 1'b1, 1'b1);
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp.rdata;
  assign bus.rsp_err     = r_rsp.err;
  assign bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: doc/apb3_eg_master.md
Name: apb3_eg_master

Overview:
- Single-outstanding APB3 initiator that turns a simple valid/ready command interface into APB3 SETUP/ACCESS transfers.
- Captures PRDATA/PSLVERR into a one-entry response register.
- Aborts a transfer with an error if the slave holds PREADY low too long.
- Sits between a local controller or test sequencer and the APB example slave register block, on the same bus.

Parameters:
- ADDRWIDTH, 12, width of cmd_addr/paddr (byte address).
- TIMEOUT, 16, number of ACCESS cycles with pready=0 before abort; 0 disables the timeout; legal range 0..255.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDRWIDTH  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDRWIDTH  APB address; bits [1:0] always 0.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Clocking and reset: one clock, pclk. preset is asynchronous and active-high.
- All outputs are registered.
- Reset values: everything 0 (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, internal wait count). State = IDLE.
- cmd_ready is combinational: (state==IDLE) && !rsp_valid.
- FSM IDLE: on accept at edge T, latch pwrite/paddr({cmd_addr[ADDRWIDTH-1:2],2'b00})/pwdata, psel<=1 → SETUP. Otherwise hold.
- FSM SETUP: exactly one cycle with psel=1, penable=0. Then penable<=1, wait count<=0 → ACCESS.
- FSM ACCESS with pready=1: complete.
  - psel<=0, penable<=0.
  - rsp_valid<=1, rsp_err<=pslverr, rsp_timeout<=0.
  - rsp_rdata<=pwrite?0:prdata.
  - → IDLE.
- FSM ACCESS with pready=0 and (TIMEOUT==0 or count<TIMEOUT-1): count+1, stay.
- FSM ACCESS with pready=0 and TIMEOUT!=0 and count==TIMEOUT-1: abort.
  - psel<=0, penable<=0.
  - rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0.
  - → IDLE.
- Priority: pready=1 on the final permitted cycle completes normally; completion wins over timeout.
- pslverr and prdata are sampled only when psel&&penable&&pready.
- Latency: accept at edge T → SETUP T+1 → ACCESS T+2 → rsp_valid high after edge T+3 with zero wait states. Each wait state adds one cycle.
- Timeout case: psel deasserts after TIMEOUT ACCESS cycles.
- paddr, pwrite, pwdata stay stable from SETUP through the end of ACCESS, and hold their last values while idle.
- Response register holds its value until rsp_valid&&rsp_ready, then rsp_valid<=0. rsp_rdata/rsp_err/rsp_timeout keep their values.
- Next command: cmd_ready rises the cycle after the response is consumed. Minimum spacing between accepts is 4 cycles with rsp_ready tied high.
- cmd_* is ignored while cmd_ready=0. The block has no command buffering.
- Reset mid-transfer: psel/penable drop immediately. Any in-flight or pending response is discarded.
- Counter width: 8 bits. Counting stops once TIMEOUT is reached.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - The response-field layout.
  - TIMEOUT_W=8.
- One sub-module is natural: apb3_eg_master_timer. It is the wait-state counter: inputs start/inc, output expired.
- Everything else stays in one always block per register group.

Test Plan:
- Write, zero wait: cmd write addr 0x004, data 0xDEADBEEF; slave pready=1.
  - psel T+1, penable T+2, paddr=0x004, pwdata=0xDEADBEEF.
  - rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: read addr 0x000; slave returns 0x12345678 after 3 ACCESS cycles of pready=0.
  - rsp_valid at T+6 with rsp_rdata=0x12345678, rsp_err=0.
  - paddr stable throughout.
- Slave error: read addr 0xFF0 with pslverr=1, pready=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout: TIMEOUT=16, pready held 0 → psel drops after exactly 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pready=1 on the 16th ACCESS cycle → normal completion.
- Backpressure/unaligned: rsp_ready=0 for 5 cycles → cmd_ready stays 0 and the response holds its values. cmd_addr 0x007 → paddr 0x004.
- Async reset mid-ACCESS: assert preset → psel, penable, rsp_valid go 0 without waiting for a clock edge. After release, a new command completes normally.
